// File: rtl/tecmo_sdram_arbiter_pkg.sv
// Shared types and constants for the tecmo SDRAM arbiter slice.
package tecmo_sdram_pkg;

   localparam int SDRAM_ADDR_W = 23;
   localparam int SDRAM_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_ACK   = 2'd1,
      WAIT_VALID = 2'd2
   } arb_state_t;

   // Width of a register able to hold a port index; never narrower than 1 bit.
   function automatic int port_idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tecmo_sdram_arbiter_if.sv
// SDRAM controller request/response bus. master = arbiter, slave = controller.
interface tecmo_sdram_arbiter_if
   import tecmo_sdram_pkg::*;
#(
   parameter int ADDR_W = SDRAM_ADDR_W,
   parameter int DATA_W = SDRAM_DATA_W
);
   logic [ADDR_W-1:0] sdram_addr;
   logic [DATA_W-1:0] sdram_data;
   logic              sdram_we;
   logic              sdram_req;
   logic              sdram_ack;
   logic              sdram_valid;
   logic [DATA_W-1:0] sdram_q;

   modport master (
      output sdram_addr, sdram_data, sdram_we, sdram_req,
      input  sdram_ack, sdram_valid, sdram_q
   );

   modport slave (
      input  sdram_addr, sdram_data, sdram_we, sdram_req,
      output sdram_ack, sdram_valid, sdram_q
   );
endinterface

// File: rtl/tecmo_sdram_arbiter_packer.sv
// Download byte packer: assembles little-endian 32-bit words from ioctl bytes,
// holds one completed word for the arbiter, flags overrun when a completed
// word overwrites one that was never taken.
module tecmo_dl_packer
   import tecmo_sdram_pkg::*;
#(
   parameter int                ADDR_W  = SDRAM_ADDR_W,
   parameter int                DATA_W  = SDRAM_DATA_W,
   parameter logic [ADDR_W-1:0] DL_BASE = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              download,
   input  logic [19:0]       ioctl_addr,
   input  logic [7:0]        ioctl_data,
   input  logic              ioctl_wr,
   input  logic              pop,
   output logic              pend_valid,
   output logic [ADDR_W-1:0] pend_addr,
   output logic [DATA_W-1:0] pend_data,
   output logic              overrun
);

   logic [23:0]       low_bytes;
   logic              byte_wr;
   logic              word_done;
   logic [ADDR_W-1:0] word_addr;

   assign byte_wr   = ioctl_wr & download;
   assign word_done = byte_wr & (ioctl_addr[1:0] == 2'd3);
   assign word_addr = DL_BASE + ADDR_W'(ioctl_addr[19:2]);

   // Collect bytes 0..2 of the current word; a partial word is dropped when download falls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         low_bytes <= '0;
      end else if (!download) begin
         low_bytes <= '0;
      end else if (byte_wr) begin
         case (ioctl_addr[1:0])
            2'd0:    low_bytes[7:0]   <= ioctl_data;
            2'd1:    low_bytes[15:8]  <= ioctl_data;
            2'd2:    low_bytes[23:16] <= ioctl_data;
            default: low_bytes        <= '0;
         endcase
      end
   end

   // Single pending slot; a word completing in the pop cycle refills it without overrun.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_valid <= 1'b0;
         pend_addr  <= '0;
         pend_data  <= '0;
         overrun    <= 1'b0;
      end else if (word_done) begin
         pend_valid <= 1'b1;
         pend_addr  <= word_addr;
         pend_data  <= DATA_W'({ioctl_data, low_bytes});
         if (pend_valid && !pop) overrun <= 1'b1;
      end else if (pop) begin
         pend_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/tecmo_sdram_arbiter.sv
// Shares one SDRAM controller port between the ROM download writer and
// NUM_PORTS ROM read requesters, one transaction outstanding at a time.
// Build option: TECMO_SDRAM_ARB_RR_EN selects round-robin among ROM ports;
// otherwise the lowest-index requesting port wins.
module tecmo_sdram_arbiter
   import tecmo_sdram_pkg::*;
#(
   parameter int                NUM_PORTS = 4,
   parameter int                ADDR_W    = SDRAM_ADDR_W,
   parameter int                DATA_W    = SDRAM_DATA_W,
   parameter logic [ADDR_W-1:0] DL_BASE   = '0
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        download,
   input  logic [19:0]                 ioctl_addr,
   input  logic [7:0]                  ioctl_data,
   input  logic                        ioctl_wr,
   input  logic [NUM_PORTS-1:0]        rom_req,
   input  logic [NUM_PORTS*ADDR_W-1:0] rom_addr,
   output logic [NUM_PORTS-1:0]        rom_ack,
   output logic [NUM_PORTS-1:0]        rom_valid,
   output logic [DATA_W-1:0]           rom_q,
   tecmo_sdram_arbiter_if.master       sdram,
   output logic                        busy,
   output logic                        overrun
);

   localparam int          IDX_W = port_idx_w(NUM_PORTS);
   localparam int unsigned NP_U  = NUM_PORTS;

   arb_state_t        state;
   logic [IDX_W-1:0]  owner;
   logic [IDX_W-1:0]  sel_port;
   logic              sel_hit;
   logic              dl_pop;
   logic              dl_pend_valid;
   logic [ADDR_W-1:0] dl_pend_addr;
   logic [DATA_W-1:0] dl_pend_data;
   logic [ADDR_W-1:0] port_addr [NUM_PORTS];

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_addr
      assign port_addr[g] = rom_addr[g*ADDR_W +: ADDR_W];
   end

   tecmo_dl_packer #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .DL_BASE (DL_BASE)
   ) u_packer (
      .clk        (clk),
      .reset_n    (reset_n),
      .download   (download),
      .ioctl_addr (ioctl_addr),
      .ioctl_data (ioctl_data),
      .ioctl_wr   (ioctl_wr),
      .pop        (dl_pop),
      .pend_valid (dl_pend_valid),
      .pend_addr  (dl_pend_addr),
      .pend_data  (dl_pend_data),
      .overrun    (overrun)
   );

   assign dl_pop = (state == IDLE) && dl_pend_valid;
   assign busy   = (state != IDLE);

`ifdef TECMO_SDRAM_ARB_RR_EN
   logic [IDX_W-1:0] last_port;
   int unsigned      rr_idx;

   // Round-robin: first requester at or after the port following the last grant.
   always_comb begin
      sel_hit  = 1'b0;
      sel_port = '0;
      rr_idx   = 0;
      for (int unsigned k = 0; k < NP_U; k++) begin
         rr_idx = (32'(last_port) + 1 + k) % NP_U;
         if (!sel_hit && rom_req[rr_idx[IDX_W-1:0]]) begin
            sel_hit  = 1'b1;
            sel_port = rr_idx[IDX_W-1:0];
         end
      end
   end

   // Remember the most recently granted ROM port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_port <= IDX_W'(NUM_PORTS - 1);
      end else if (state == IDLE && !dl_pend_valid && !download && sel_hit) begin
         last_port <= sel_port;
      end
   end
`else
   // Fixed priority: lowest requesting port index wins.
   always_comb begin
      sel_hit  = 1'b0;
      sel_port = '0;
      for (int unsigned k = 0; k < NP_U; k++) begin
         if (!sel_hit && rom_req[k[IDX_W-1:0]]) begin
            sel_hit  = 1'b1;
            sel_port = k[IDX_W-1:0];
         end
      end
   end
`endif

   // Transaction FSM: grant in IDLE, hold request until ack, route read data to the latched owner.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         owner            <= '0;
         sdram.sdram_req  <= 1'b0;
         sdram.sdram_we   <= 1'b0;
         sdram.sdram_addr <= '0;
         sdram.sdram_data <= '0;
         rom_ack          <= '0;
         rom_valid        <= '0;
         rom_q            <= '0;
      end else begin
         rom_ack   <= '0;
         rom_valid <= '0;
         case (state)
            IDLE: begin
               if (dl_pend_valid) begin
                  sdram.sdram_req  <= 1'b1;
                  sdram.sdram_we   <= 1'b1;
                  sdram.sdram_addr <= dl_pend_addr;
                  sdram.sdram_data <= dl_pend_data;
                  state            <= WAIT_ACK;
               end else if (!download && sel_hit) begin
                  sdram.sdram_req  <= 1'b1;
                  sdram.sdram_we   <= 1'b0;
                  sdram.sdram_addr <= port_addr[sel_port];
                  owner            <= sel_port;
                  state            <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (sdram.sdram_ack) begin
                  sdram.sdram_req <= 1'b0;
                  sdram.sdram_we  <= 1'b0;
                  if (sdram.sdram_we) begin
                     state <= IDLE;
                  end else begin
                     rom_ack[owner] <= 1'b1;
                     // Controller may return data in the ack cycle; finish the read here.
                     if (sdram.sdram_valid) begin
                        rom_valid[owner] <= 1'b1;
                        rom_q            <= sdram.sdram_q;
                        state            <= IDLE;
                     end else begin
                        state <= WAIT_VALID;
                     end
                  end
               end
            end
            WAIT_VALID: begin
               if (sdram.sdram_valid) begin
                  rom_valid[owner] <= 1'b1;
                  rom_q            <= sdram.sdram_q;
                  state            <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
